// File: rtl/aidc_comp_select_n_if.sv
// Bus bundle for the compressed write-data tail selector: raw beats in, engine results in, selected beats out.
interface aidc_comp_select_n_if #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned BEATS   = 4,
  parameter int unsigned NUM_ENG = 3
);
  localparam int unsigned BPB      = DATA_W / 8;
  localparam int unsigned SIZE_W   = $clog2(BEATS * BPB) + 1;
  localparam int unsigned ENG_ID_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  logic                              force_raw;
  logic [NUM_ENG-1:0]                eng_en;
  logic                              in_valid;
  logic                              in_ready;
  logic [DATA_W-1:0]                 in_data;
  logic                              in_last;
  logic [NUM_ENG-1:0]                eng_valid;
  logic [NUM_ENG-1:0]                eng_ready;
  logic [NUM_ENG*SIZE_W-1:0]         eng_size;
  logic [NUM_ENG*BEATS*DATA_W-1:0]   eng_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [DATA_W-1:0]                 out_data;
  logic                              out_last;
  logic                              out_comp;
  logic [ENG_ID_W-1:0]               out_eng_id;
  logic                              err_len;

  // Upstream/downstream side (drives raw beats, engine results and out_ready)
  modport master (
    output force_raw, eng_en, in_valid, in_data, in_last,
           eng_valid, eng_size, eng_data, out_ready,
    input  in_ready, eng_ready, out_valid, out_data, out_last,
           out_comp, out_eng_id, err_len
  );

  // Selector side
  modport slave (
    input  force_raw, eng_en, in_valid, in_data, in_last,
           eng_valid, eng_size, eng_data, out_ready,
    output in_ready, eng_ready, out_valid, out_data, out_last,
           out_comp, out_eng_id, err_len
  );
endinterface

// File: rtl/aidc_comp_select_n.sv
// Per-packet selector: buffers one raw packet plus one result per engine, then emits the smallest
// eligible result (or the raw packet) as a beat stream tagged with compressed flag and engine id.
module aidc_comp_select_n #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned BEATS   = 4,
  parameter int unsigned NUM_ENG = 3
) (
  input  logic                clk,
  input  logic                rst,
  aidc_comp_select_n_if.slave bus
);
  localparam int unsigned BPB       = DATA_W / 8;
  localparam int unsigned RAW_BYTES = BEATS * BPB;
  localparam int unsigned SIZE_W    = $clog2(BEATS * BPB) + 1;
  localparam int unsigned ENG_ID_W  = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned NB_W      = $clog2(BEATS + 1);
  localparam int unsigned CALC_W    = SIZE_W + 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {COLLECT, DECIDE, SEND} state_t;

  state_t                                   state_q, state_d;
  logic [CNT_W-1:0]                         cnt_q;
  logic                                     raw_done_q;
  logic                                     len_err_q;
  logic [BEATS-1:0][DATA_W-1:0]             raw_buf_q;
  logic [NUM_ENG-1:0]                       held_q;
  logic [NUM_ENG-1:0][SIZE_W-1:0]           size_q;
  logic [NUM_ENG-1:0][BEATS-1:0][DATA_W-1:0] eng_buf_q;
  logic                                     comp_q;
  logic [ENG_ID_W-1:0]                      eng_id_q;
  logic [NB_W-1:0]                          nb_q;
  logic [CNT_W-1:0]                         k_q;

  logic                 in_take, end_beat, len_err_now, out_take, send_done;
  logic [NUM_ENG-1:0]   held_set;
  logic [CNT_W-1:0]     k_last;
  logic [CALC_W-1:0]    nb_calc, best_calc;
  logic                 best_found, use_comp;
  logic [ENG_ID_W-1:0]  best_id;

  // Handshake decode; a packet ends on in_last or on the final slot, mismatch of the two is a length error
  always_comb begin
    in_take     = (state_q == COLLECT) && !raw_done_q && bus.in_valid;
    end_beat    = in_take && (bus.in_last || (cnt_q == LAST_SLOT));
    len_err_now = in_take && (bus.in_last != (cnt_q == LAST_SLOT));
    held_set    = (state_q == COLLECT) ? (bus.eng_valid & ~held_q & bus.eng_en) : '0;
    k_last      = CNT_W'(nb_q - NB_W'(1));
    out_take    = (state_q == SEND) && bus.out_ready;
    send_done   = out_take && (k_q == k_last);
  end

  // Smallest beat count among enabled, eligible engines; lowest index wins ties
  always_comb begin
    nb_calc    = '0;
    best_calc  = CALC_W'(BEATS);
    best_found = 1'b0;
    best_id    = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      nb_calc = (CALC_W'(size_q[i]) + CALC_W'(BPB - 1)) / CALC_W'(BPB);
      if (nb_calc == '0) nb_calc = CALC_W'(1);
      if (bus.eng_en[i] && (size_q[i] <= SIZE_W'(RAW_BYTES)) &&
          (!best_found || (nb_calc < best_calc))) begin
        best_found = 1'b1;
        best_calc  = nb_calc;
        best_id    = ENG_ID_W'(i);
      end
    end
    use_comp = best_found && !bus.force_raw && !len_err_q && (best_calc < CALC_W'(BEATS));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  // Next state: leave COLLECT once raw packet and every enabled engine are in (same cycle allowed)
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if ((raw_done_q || end_beat) && (&(held_q | held_set | ~bus.eng_en))) state_d = DECIDE;
      DECIDE:  state_d = SEND;
      SEND:    if (send_done) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Outputs decoded from state and held registers; err_len flags the accepting cycle
  always_comb begin
    bus.in_ready   = (state_q == COLLECT) && !raw_done_q;
    bus.eng_ready  = (state_q == COLLECT) ? ~held_q : '0;
    bus.out_valid  = (state_q == SEND);
    bus.out_data   = '0;
    bus.out_last   = 1'b0;
    bus.out_comp   = 1'b0;
    bus.out_eng_id = '0;
    bus.err_len    = len_err_now;
    if (state_q == SEND) begin
      bus.out_data   = comp_q ? eng_buf_q[eng_id_q][k_q] : raw_buf_q[k_q];
      bus.out_last   = (k_q == k_last);
      bus.out_comp   = comp_q;
      bus.out_eng_id = eng_id_q;
    end
  end

  // Packet buffers, held flags and the per-packet decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      raw_done_q <= 1'b0;
      len_err_q  <= 1'b0;
      raw_buf_q  <= '0;
      held_q     <= '0;
      size_q     <= '0;
      eng_buf_q  <= '0;
      comp_q     <= 1'b0;
      eng_id_q   <= '0;
      nb_q       <= '0;
      k_q        <= '0;
    end else begin
      if (in_take) begin
        raw_buf_q[cnt_q] <= bus.in_data;
        if (end_beat) raw_done_q <= 1'b1;
        else          cnt_q      <= cnt_q + CNT_W'(1);
        if (len_err_now) len_err_q <= 1'b1;
      end
      for (int i = 0; i < NUM_ENG; i++) begin
        if (held_set[i]) begin
          held_q[i]    <= 1'b1;
          size_q[i]    <= bus.eng_size[i*SIZE_W +: SIZE_W];
          eng_buf_q[i] <= bus.eng_data[i*BEATS*DATA_W +: BEATS*DATA_W];
        end
      end
      if (state_q == DECIDE) begin
        comp_q   <= use_comp;
        eng_id_q <= use_comp ? best_id : '0;
        nb_q     <= use_comp ? NB_W'(best_calc) : NB_W'(BEATS);
        k_q      <= '0;
      end
      if (out_take) begin
        if (send_done) begin
          cnt_q      <= '0;
          raw_done_q <= 1'b0;
          len_err_q  <= 1'b0;
          raw_buf_q  <= '0;
          held_q     <= '0;
          comp_q     <= 1'b0;
          eng_id_q   <= '0;
          nb_q       <= '0;
          k_q        <= '0;
        end else begin
          k_q <= k_q + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_aidc_comp_select_n.sv
// Directed bench for aidc_comp_select_n: selection, ties, enables, length errors, stalls, force-raw, reset.
module tb_aidc_comp_select_n;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned BEATS   = 4;
  localparam int unsigned NUM_ENG = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aidc_comp_select_n_if #(.DATA_W(DATA_W), .BEATS(BEATS), .NUM_ENG(NUM_ENG)) bus ();

  aidc_comp_select_n #(.DATA_W(DATA_W), .BEATS(BEATS), .NUM_ENG(NUM_ENG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] raw [4];
  logic [63:0] got [8];
  logic        got_comp [8];
  logic [1:0]  got_id [8];
  int          got_n;
  int          nerr;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] edat(input int seed, input int i, input int k);
    return 64'hE000_0000_0000_0000 | (64'(seed) << 16) | (64'(i) << 8) | 64'(k);
  endfunction

  task automatic set_pkt(input int seed, input int s0, input int s1, input int s2);
    for (int k = 0; k < 4; k++) raw[k] = 64'hA000_0000_0000_0000 | (64'(seed) << 16) | 64'(k);
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 4; k++) bus.eng_data[(i*4+k)*64 +: 64] = edat(seed, i, k);
    bus.eng_size = {6'(s2), 6'(s1), 6'(s0)};
  endtask

  // Offer nraw raw beats (last flag at last_at) and the engine results in ev; counts err_len pulses
  task automatic collect(input int nraw, input int last_at, input logic [2:0] ev, input int raw_delay,
                         output int n_err);
    int b = 0;
    int cyc = 0;
    logic [2:0] pend = ev;
    logic acc_in;
    logic [2:0] acc_eng;
    n_err = 0;
    while ((b < nraw || pend != 3'b000) && cyc < 40) begin
      bus.in_valid  = (b < nraw) && (cyc >= raw_delay);
      bus.in_data   = (b < nraw) ? raw[b] : 64'h0;
      bus.in_last   = (b == last_at);
      bus.eng_valid = pend;
      #1;
      if (bus.err_len) n_err++;
      acc_in  = bus.in_valid && bus.in_ready;
      acc_eng = pend & bus.eng_ready;
      @(negedge clk);
      if (acc_in) b++;
      pend = pend & ~acc_eng;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.eng_valid = 3'b000;
    chk("collect_done", 128'(cyc < 40), 128'(1));
  endtask

  // Drain one output packet; checks no overlap and output stability while stalled
  task automatic recv(input bit rnd);
    int cyc = 0;
    bit done = 1'b0;
    bit stalled = 1'b0;
    logic [67:0] snap = '0;
    logic [67:0] cur;
    got_n = 0;
    while (!done && cyc < 60) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      cur = {bus.out_last, bus.out_comp, bus.out_eng_id, bus.out_data};
      if (bus.out_valid) begin
        chk("send_in_ready", 128'(bus.in_ready), 128'(0));
        chk("send_eng_ready", 128'(bus.eng_ready), 128'(0));
        if (stalled) chk("stall_hold", 128'(cur), 128'(snap));
        if (bus.out_ready) begin
          if (got_n < 8) begin
            got[got_n]      = bus.out_data;
            got_comp[got_n] = bus.out_comp;
            got_id[got_n]   = bus.out_eng_id;
          end
          got_n++;
          if (bus.out_last) done = 1'b1;
          stalled = 1'b0;
        end else begin
          snap    = cur;
          stalled = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    chk("recv_done", 128'(done), 128'(1));
    #1;
    chk("idle_out_valid", 128'(bus.out_valid), 128'(0));
    chk("idle_out_comp", 128'(bus.out_comp), 128'(0));
  endtask

  // Compare the drained packet against nexp beats from engine id (comp) or raw slots (nraw valid, rest zero)
  task automatic chk_pkt(input string tag, input int nexp, input logic comp, input int id,
                         input int seed, input int nraw);
    logic [63:0] e;
    chk({tag, "_nbeats"}, 128'(got_n), 128'(nexp));
    for (int k = 0; k < nexp && k < got_n && k < 8; k++) begin
      e = comp ? edat(seed, id, k) : ((k < nraw) ? raw[k] : 64'h0);
      chk({tag, "_data"}, 128'(got[k]), 128'(e));
      chk({tag, "_comp"}, 128'(got_comp[k]), 128'(comp));
      chk({tag, "_id"}, 128'(got_id[k]), 128'(id));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.force_raw = 1'b0;
    bus.eng_en    = 3'b111;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.eng_valid = '0;
    bus.eng_size  = '0;
    bus.eng_data  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_eng_ready", 128'(bus.eng_ready), 128'(3'b111));
    chk("rst_outs", 128'({bus.out_valid, bus.out_last, bus.out_comp, bus.out_eng_id, bus.err_len}), 128'(0));
    chk("rst_out_data", 128'(bus.out_data), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // T1: engine 1 smallest (nb 3,2,4), engines presented before raw
    set_pkt(1, 20, 9, 32);
    collect(4, 3, 3'b111, 2, nerr);
    chk("t1_err", 128'(nerr), 128'(0));
    recv(1'b0);
    chk_pkt("t1", 2, 1'b1, 1, 1, 4);

    // T2: best nb 4 is not smaller than the packet -> raw
    set_pkt(2, 32, 32, 30);
    collect(4, 3, 3'b111, 0, nerr);
    recv(1'b0);
    chk_pkt("t2", 4, 1'b0, 0, 2, 4);

    // T3: tie at one beat resolves to engine 0; 40 bytes is ineligible
    set_pkt(3, 8, 8, 40);
    collect(4, 3, 3'b111, 0, nerr);
    recv(1'b0);
    chk_pkt("t3a", 1, 1'b1, 0, 3, 4);

    // T3: engine 0 disabled but still offering -> drained, engine 1 chosen
    bus.eng_en = 3'b110;
    set_pkt(4, 8, 8, 40);
    collect(4, 3, 3'b111, 0, nerr);
    recv(1'b0);
    chk_pkt("t3b", 1, 1'b1, 1, 4, 4);
    bus.eng_en = 3'b111;

    // T4: early last on beat 1 -> one err pulse, raw with zero-filled tail
    set_pkt(5, 8, 8, 8);
    collect(2, 1, 3'b111, 0, nerr);
    chk("t4a_err", 128'(nerr), 128'(1));
    recv(1'b0);
    chk_pkt("t4a", 4, 1'b0, 0, 5, 2);

    // T4: four beats without last -> err pulse, no fifth beat accepted
    set_pkt(6, 8, 8, 8);
    collect(4, -1, 3'b111, 0, nerr);
    chk("t4b_err", 128'(nerr), 128'(1));
    #1;
    chk("t4b_in_ready", 128'(bus.in_ready), 128'(0));
    recv(1'b0);
    chk_pkt("t4b", 4, 1'b0, 0, 6, 4);

    // T5: random backpressure on a raw packet
    set_pkt(7, 32, 32, 32);
    collect(4, 3, 3'b111, 0, nerr);
    recv(1'b1);
    chk_pkt("t5a", 4, 1'b0, 0, 7, 4);

    // T5: force_raw overrides zero-size results
    bus.force_raw = 1'b1;
    set_pkt(8, 0, 0, 0);
    collect(4, 3, 3'b111, 0, nerr);
    recv(1'b1);
    chk_pkt("t5b", 4, 1'b0, 0, 8, 4);
    bus.force_raw = 1'b0;

    // Size 0 counts as one beat; 33 bytes ineligible; tie with engine 2 goes to engine 0
    set_pkt(9, 0, 33, 8);
    collect(4, 3, 3'b111, 0, nerr);
    recv(1'b1);
    chk_pkt("t5c", 1, 1'b1, 0, 9, 4);

    // nb 4,3,ineligible -> engine 1 with three beats
    set_pkt(12, 25, 24, 33);
    collect(4, 3, 3'b111, 0, nerr);
    recv(1'b1);
    chk_pkt("t5d", 3, 1'b1, 1, 12, 4);

    // T6: reset mid-packet discards partial state
    set_pkt(10, 8, 8, 8);
    collect(2, -1, 3'b001, 0, nerr);
    rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("t6_rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("t6_rst_eng_ready", 128'(bus.eng_ready), 128'(3'b111));
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("t6_idle_out_valid", 128'(bus.out_valid), 128'(0));
    end
    set_pkt(11, 20, 9, 32);
    collect(4, 3, 3'b111, 0, nerr);
    chk("t6_err", 128'(nerr), 128'(0));
    recv(1'b0);
    chk_pkt("t6", 2, 1'b1, 1, 11, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
